// File: rtl/ulpb_pkg.sv
`default_nettype none
// ==========================================================================
// ulpb_pkg : shared types and helpers for the ulpb TX/RX schedulers  (rev 1.0)
// ==========================================================================
package ulpb_pkg;

  localparam int ULPB_ADDR_WIDTH = 8;
  localparam int ULPB_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD0  = 3'd1,
    LOAD1  = 3'd2,
    REQ    = 3'd3,
    STREAM = 3'd4
  } tx_state_e;

  // Ceiling log2, never below 1 so single-bit indices stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ulpb_rr_arbiter.sv
`default_nettype none
// ==========================================================================
// ulpb_rr_arbiter : combinational round-robin pick starting at ptr  (rev 1.0)
// ==========================================================================
module ulpb_rr_arbiter
  import ulpb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_off;

  // Rotate so the pointer position lands at bit 0; lowest set bit wins.
  assign w_rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    valid = 1'b0;
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        valid = 1'b1;
        w_off = IDX_W'(i);
      end
    end
  end

  assign grant = IDX_W'((int'(ptr) + int'(w_off)) % N_REQ);

endmodule
`default_nettype wire

// File: rtl/ulpb_tx_sched.sv
`default_nettype none
// ==========================================================================
// ulpb_tx_sched : round-robin TX scheduler feeding one ulpb_node32 port  (rev 1.0)
// ==========================================================================
module ulpb_tx_sched
  import ulpb_pkg::*;
#(
  parameter int N_CLIENTS   = 3,
  parameter int ADDR_WIDTH  = ULPB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = ULPB_DATA_WIDTH,
  parameter int ACK_TIMEOUT = 1024,
  localparam int GW = clog2(N_CLIENTS)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [N_CLIENTS-1:0]            CL_REQ,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0] CL_ADDR,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0] CL_DATA,
  input  logic [N_CLIENTS-1:0]            CL_LAST,
  output logic [N_CLIENTS-1:0]            CL_WACK,
  output logic [N_CLIENTS-1:0]            CL_DONE,
  output logic [N_CLIENTS-1:0]            CL_FAIL,
  output logic [ADDR_WIDTH-1:0]           ADDR_IN,
  output logic [DATA_WIDTH-1:0]           DATA_IN0,
  output logic [DATA_WIDTH-1:0]           DATA_IN1,
  output logic                            PENDING,
  output logic                            REQ_TX,
  input  logic                            ACK_TX,
  input  logic                            WORD_INDICATOR,
  input  logic                            ACK_RECEIVED,
  input  logic                            TX_FAIL,
  output logic                            BUSY,
  output logic [GW-1:0]                   GRANT_ID
);

  localparam int TW = clog2(ACK_TIMEOUT);

  tx_state_e              state_q, state_d;
  logic [GW-1:0]          ptr_q, ptr_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data0_q, data0_d;
  logic [DATA_WIDTH-1:0]  data1_q, data1_d;
  logic                   pending_q, pending_d;
  logic                   req_tx_q, req_tx_d;
  logic                   busy_q, busy_d;
  logic                   sel_q, sel_d;
  logic                   wi_ref_q, wi_ref_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [N_CLIENTS-1:0]   done_q, done_d;
  logic [N_CLIENTS-1:0]   fail_q, fail_d;

  logic [DATA_WIDTH-1:0]  w_cl_data [N_CLIENTS];
  logic [ADDR_WIDTH-1:0]  w_cl_addr [N_CLIENTS];
  logic [N_CLIENTS-1:0]   w_arb_req;
  logic [GW-1:0]          w_arb_grant;
  logic                   w_arb_valid;
  logic [N_CLIENTS-1:0]   w_wack;
  logic [DATA_WIDTH-1:0]  w_data_g;
  logic                   w_last_g;
  logic                   w_req_g;
  logic                   w_wi_edge;
  logic                   w_timeout;
  logic [GW-1:0]          w_ptr_next;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_unpack
    assign w_cl_data[i] = CL_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_cl_addr[i] = CL_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // A client finishing this cycle still shows CL_REQ; keep it out of the next pick.
  assign w_arb_req = CL_REQ & ~(done_q | fail_q);

  ulpb_rr_arbiter #(
    .N_REQ (N_CLIENTS),
    .IDX_W (GW)
  ) u_arb (
    .req   (w_arb_req),
    .ptr   (ptr_q),
    .grant (w_arb_grant),
    .valid (w_arb_valid)
  );

  assign w_data_g   = w_cl_data[grant_q];
  assign w_last_g   = CL_LAST[grant_q];
  assign w_req_g    = CL_REQ[grant_q];
  assign w_wi_edge  = WORD_INDICATOR ^ wi_ref_q;
  assign w_timeout  = (tmo_cnt_q == TW'(ACK_TIMEOUT - 1));
  assign w_ptr_next = (grant_q == GW'(N_CLIENTS - 1)) ? '0 : grant_q + GW'(1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      pending_q <= 1'b0;
      req_tx_q  <= 1'b0;
      busy_q    <= 1'b0;
      sel_q     <= 1'b0;
      wi_ref_q  <= 1'b0;
      tmo_cnt_q <= '0;
      done_q    <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      pending_q <= pending_d;
      req_tx_q  <= req_tx_d;
      busy_q    <= busy_d;
      sel_q     <= sel_d;
      wi_ref_q  <= wi_ref_d;
      tmo_cnt_q <= tmo_cnt_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (w_arb_valid) state_d = LOAD0;
      LOAD0:   state_d = w_last_g ? REQ : LOAD1;
      LOAD1:   state_d = REQ;
      REQ: begin
        if (ACK_TX)         state_d = STREAM;
        else if (w_timeout) state_d = IDLE;
      end
      STREAM:  if (ACK_RECEIVED || TX_FAIL) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    pending_d = pending_q;
    req_tx_d  = req_tx_q;
    busy_d    = busy_q;
    sel_d     = sel_q;
    wi_ref_d  = wi_ref_q;
    tmo_cnt_d = tmo_cnt_q;
    done_d    = '0;
    fail_d    = '0;
    w_wack    = '0;
    unique case (state_q)
      IDLE: begin
        if (w_arb_valid) begin
          grant_d   = w_arb_grant;
          addr_d    = w_cl_addr[w_arb_grant];
          busy_d    = 1'b1;
          pending_d = 1'b0;
        end
      end
      LOAD0: begin
        data0_d          = w_data_g;
        w_wack[grant_q]  = 1'b1;
        if (w_last_g) begin
          pending_d = 1'b0;
          req_tx_d  = 1'b1;
          tmo_cnt_d = '0;
        end
      end
      LOAD1: begin
        data1_d          = w_data_g;
        w_wack[grant_q]  = 1'b1;
        pending_d        = ~w_last_g;
        req_tx_d         = 1'b1;
        tmo_cnt_d        = '0;
      end
      REQ: begin
        if (ACK_TX) begin
          req_tx_d  = 1'b0;
          wi_ref_d  = WORD_INDICATOR;
          sel_d     = 1'b0;
          tmo_cnt_d = '0;
        end else if (w_timeout) begin
          req_tx_d        = 1'b0;
          fail_d[grant_q] = 1'b1;
          busy_d          = 1'b0;
          pending_d       = 1'b0;
          ptr_d           = w_ptr_next;
          tmo_cnt_d       = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      STREAM: begin
        if (ACK_RECEIVED || TX_FAIL) begin
          // TX_FAIL takes precedence when both arrive together.
          if (TX_FAIL) fail_d[grant_q] = 1'b1;
          else         done_d[grant_q] = 1'b1;
          busy_d    = 1'b0;
          pending_d = 1'b0;
          ptr_d     = w_ptr_next;
        end else if (w_wi_edge) begin
          wi_ref_d = WORD_INDICATOR;
          sel_d    = ~sel_q;
          if (pending_q) begin
            if (w_req_g) begin
              if (sel_q) data1_d = w_data_g;
              else       data0_d = w_data_g;
              w_wack[grant_q] = 1'b1;
              pending_d       = ~w_last_g;
            end else begin
              pending_d = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign CL_WACK  = w_wack;
  assign CL_DONE  = done_q;
  assign CL_FAIL  = fail_q;
  assign ADDR_IN  = addr_q;
  assign DATA_IN0 = data0_q;
  assign DATA_IN1 = data1_q;
  assign PENDING  = pending_q;
  assign REQ_TX   = req_tx_q;
  assign BUSY     = busy_q;
  assign GRANT_ID = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_ulpb_tx_sched.sv
`default_nettype none
// ==========================================================================
// tb_ulpb_tx_sched : scoreboard bench for ulpb_tx_sched  (rev 1.0)
// ==========================================================================
module tb_ulpb_tx_sched;

  localparam int N        = 3;
  localparam int AW       = 8;
  localparam int DW       = 32;
  localparam int TMO      = 1024;
  localparam int GW       = 2;
  localparam int REQ_WAIT = 20;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N-1:0]    CL_REQ;
  logic [N*AW-1:0] CL_ADDR;
  logic [N*DW-1:0] CL_DATA;
  logic [N-1:0]    CL_LAST;
  logic [N-1:0]    CL_WACK, CL_DONE, CL_FAIL;
  logic [AW-1:0]   ADDR_IN;
  logic [DW-1:0]   DATA_IN0, DATA_IN1;
  logic            PENDING, REQ_TX, ACK_TX, WORD_INDICATOR, ACK_RECEIVED, TX_FAIL, BUSY;
  logic [GW-1:0]   GRANT_ID;

  typedef struct {
    int          client;
    int          slot;
    logic [DW-1:0] word;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] words [N][4];
  logic [AW-1:0] caddr [N];
  int            wcnt [N];
  int            widx [N];
  int            wack_cnt [N];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 CLK = ~CLK;

  for (genvar c = 0; c < N; c++) begin : g_client
    assign CL_DATA[c*DW +: DW] = (widx[c] < 4) ? words[c][widx[c]] : '0;
    assign CL_ADDR[c*AW +: AW] = caddr[c];
    assign CL_LAST[c]          = (widx[c] == wcnt[c] - 1);
  end

  ulpb_tx_sched #(
    .N_CLIENTS   (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CL_REQ         (CL_REQ),
    .CL_ADDR        (CL_ADDR),
    .CL_DATA        (CL_DATA),
    .CL_LAST        (CL_LAST),
    .CL_WACK        (CL_WACK),
    .CL_DONE        (CL_DONE),
    .CL_FAIL        (CL_FAIL),
    .ADDR_IN        (ADDR_IN),
    .DATA_IN0       (DATA_IN0),
    .DATA_IN1       (DATA_IN1),
    .PENDING        (PENDING),
    .REQ_TX         (REQ_TX),
    .ACK_TX         (ACK_TX),
    .WORD_INDICATOR (WORD_INDICATOR),
    .ACK_RECEIVED   (ACK_RECEIVED),
    .TX_FAIL        (TX_FAIL),
    .BUSY           (BUSY),
    .GRANT_ID       (GRANT_ID)
  );

  // Client model + scoreboard: on each word-ack advance the client and check the slot.
  initial begin : p_client_sb
    logic [N-1:0] wsnap;
    exp_t         e;
    int           wc;
    logic [DW-1:0] got;
    forever begin
      @(negedge CLK);
      wsnap = CL_WACK;
      if ((CL_WACK | CL_DONE | CL_FAIL) != '0) begin
        n_checks++;
        if ($countones({CL_WACK, CL_DONE, CL_FAIL}) > 1) begin
          $display("FAIL onehot: wack=%b done=%b fail=%b, at most one bit required", CL_WACK, CL_DONE, CL_FAIL);
          n_fail++;
        end
      end
      if (wsnap != '0) begin
        wc = 0;
        for (int i = 0; i < N; i++) if (wsnap[i]) wc = i;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_wack: client %0d acked a word, none expected", wc);
          n_fail++;
          @(posedge CLK); #1;
          widx[wc]++;
          wack_cnt[wc]++;
        end else begin
          e = exp_q.pop_front();
          if (wc != e.client) begin
            $display("FAIL sb_wack_client: got client %0d, required %0d", wc, e.client);
            n_fail++;
          end
          @(posedge CLK); #1;
          widx[wc]++;
          wack_cnt[wc]++;
          got = e.slot ? DATA_IN1 : DATA_IN0;
          n_checks++;
          if (got !== e.word) begin
            $display("FAIL sb_slot%0d_word: got %h, required %h", e.slot, got, e.word);
            n_fail++;
          end
        end
      end
    end
  end

  initial begin : p_watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic arm(input int c, input logic [AW-1:0] a, input int n,
                     input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                     input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    exp_t e;
    words[c][0] = w0; words[c][1] = w1; words[c][2] = w2; words[c][3] = w3;
    wcnt[c] = n;
    widx[c] = 0;
    caddr[c] = a;
    for (int k = 0; k < n; k++) begin
      e.client = c; e.slot = k % 2; e.word = words[c][k];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_req(output bit ok);
    int cyc = 0;
    while (REQ_TX !== 1'b1 && cyc < REQ_WAIT) begin
      @(posedge CLK); #1;
      cyc++;
    end
    ok = (REQ_TX === 1'b1);
  endtask

  // Node side of one transfer: ACK, refill toggles, then DONE or FAIL.
  task automatic serve(input int c, input int nw, input logic [AW-1:0] a, input bit do_fail);
    bit ok;
    logic [N-1:0] exp_one;
    exp_one = N'(1) << c;
    wait_req(ok);
    n_checks++;
    if (!ok) begin
      $display("FAIL serve_req_tx: client %0d REQ_TX=%b after %0d cycles, required 1", c, REQ_TX, REQ_WAIT);
      n_fail++;
      return;
    end
    n_checks++;
    if (GRANT_ID !== GW'(c)) begin
      $display("FAIL serve_grant: GRANT_ID=%0d, required %0d", GRANT_ID, c); n_fail++;
    end
    n_checks++;
    if (ADDR_IN !== a) begin
      $display("FAIL serve_addr: ADDR_IN=%h, required %h", ADDR_IN, a); n_fail++;
    end
    n_checks++;
    if (PENDING !== (nw > 2)) begin
      $display("FAIL serve_pending_initial: PENDING=%b, required %b", PENDING, nw > 2); n_fail++;
    end
    ACK_TX = 1'b1;
    @(posedge CLK); #1;
    ACK_TX = 1'b0;
    n_checks++;
    if (REQ_TX !== 1'b0) begin
      $display("FAIL serve_req_drop: REQ_TX=%b after ACK_TX, required 0", REQ_TX); n_fail++;
    end
    for (int k = 2; k < nw; k++) begin
      WORD_INDICATOR = ~WORD_INDICATOR;
      @(posedge CLK); #1;
      n_checks++;
      if (PENDING !== (k < nw - 1)) begin
        $display("FAIL serve_pending_word%0d: PENDING=%b, required %b", k + 1, PENDING, k < nw - 1); n_fail++;
      end
      @(posedge CLK); #1;
    end
    if (do_fail) TX_FAIL = 1'b1;
    else         ACK_RECEIVED = 1'b1;
    @(posedge CLK); #1;
    TX_FAIL = 1'b0;
    ACK_RECEIVED = 1'b0;
    n_checks++;
    if (CL_DONE !== (do_fail ? '0 : exp_one) || CL_FAIL !== (do_fail ? exp_one : '0)) begin
      $display("FAIL serve_result: done=%b fail=%b, required done=%b fail=%b",
               CL_DONE, CL_FAIL, do_fail ? '0 : exp_one, do_fail ? exp_one : '0);
      n_fail++;
    end
    n_checks++;
    if (BUSY !== 1'b0) begin
      $display("FAIL serve_busy_clear: BUSY=%b, required 0", BUSY); n_fail++;
    end
    CL_REQ[c] = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({BUSY, REQ_TX, PENDING} !== 3'b000) begin
      $display("FAIL reset_ctrl: busy/req_tx/pending=%b, required 000", {BUSY, REQ_TX, PENDING}); n_fail++;
    end
    n_checks++;
    if ({DATA_IN0, DATA_IN1, ADDR_IN} !== '0) begin
      $display("FAIL reset_data: d0=%h d1=%h addr=%h, required 0", DATA_IN0, DATA_IN1, ADDR_IN); n_fail++;
    end
    n_checks++;
    if ({CL_WACK, CL_DONE, CL_FAIL, GRANT_ID} !== '0) begin
      $display("FAIL reset_pulses: wack=%b done=%b fail=%b grant=%0d, required 0", CL_WACK, CL_DONE, CL_FAIL, GRANT_ID); n_fail++;
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (BUSY !== 1'b0) begin
      $display("FAIL reset_idle_busy: BUSY=%b with no requests, required 0", BUSY); n_fail++;
    end
  endtask

  task automatic test_single_word();
    arm(0, 8'hab, 1, 32'habcdef12, '0, '0, '0);
    CL_REQ[0] = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (REQ_TX !== 1'b0 || BUSY !== 1'b1) begin
      $display("FAIL single_lat1: REQ_TX=%b BUSY=%b, required 0 1", REQ_TX, BUSY); n_fail++;
    end
    @(posedge CLK); #1;
    n_checks++;
    if (REQ_TX !== 1'b1) begin
      $display("FAIL single_lat2: REQ_TX=%b two cycles after CL_REQ, required 1", REQ_TX); n_fail++;
    end
    serve(0, 1, 8'hab, 1'b0);
  endtask

  task automatic test_four_word();
    int base;
    base = wack_cnt[1];
    arm(1, 8'h5a, 4, 32'h21fedcba, 32'habcdef12, 32'ha1b2c3d4, 32'h11223344);
    CL_REQ[1] = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (REQ_TX !== 1'b0) begin
      $display("FAIL four_lat2: REQ_TX=%b two cycles after CL_REQ, required 0", REQ_TX); n_fail++;
    end
    @(posedge CLK); #1;
    n_checks++;
    if (REQ_TX !== 1'b1) begin
      $display("FAIL four_lat3: REQ_TX=%b three cycles after CL_REQ, required 1", REQ_TX); n_fail++;
    end
    serve(1, 4, 8'h5a, 1'b0);
    n_checks++;
    if (wack_cnt[1] - base != 4) begin
      $display("FAIL four_wack_count: %0d word acks, required 4", wack_cnt[1] - base); n_fail++;
    end
  endtask

  task automatic test_arbitration();
    arm(0, 8'hcd, 1, 32'h00000a0a, '0, '0, '0);
    arm(1, 8'hcd, 1, 32'h00000b0b, '0, '0, '0);
    CL_REQ = 3'b011;
    serve(0, 1, 8'hcd, 1'b0);
    serve(1, 1, 8'hcd, 1'b0);
    arm(2, 8'he2, 1, 32'h2222aaaa, '0, '0, '0);
    arm(0, 8'he0, 1, 32'h0000aaaa, '0, '0, '0);
    arm(1, 8'he1, 1, 32'h1111aaaa, '0, '0, '0);
    CL_REQ = 3'b111;
    serve(2, 1, 8'he2, 1'b0);
    serve(0, 1, 8'he0, 1'b0);
    serve(1, 1, 8'he1, 1'b0);
  endtask

  task automatic test_failure();
    arm(2, 8'h77, 3, 32'hc0de0001, 32'hc0de0002, 32'hc0de0003, '0);
    CL_REQ[2] = 1'b1;
    serve(2, 3, 8'h77, 1'b1);
  endtask

  // Clients 0 and 2 together: client 0 winning proves the pointer wrapped to 0.
  task automatic test_timeout();
    bit ok;
    int hi;
    arm(0, 8'h10, 1, 32'h7e7e0000, '0, '0, '0);
    arm(2, 8'h22, 3, 32'h5a5a0001, 32'h5a5a0002, 32'h5a5a0003, '0);
    CL_REQ = 3'b101;
    wait_req(ok);
    n_checks++;
    if (!ok || GRANT_ID !== 2'd0) begin
      $display("FAIL timeout_grant: req_tx=%b grant=%0d, required 1 and 0", REQ_TX, GRANT_ID); n_fail++;
    end
    hi = 0;
    while (REQ_TX === 1'b1 && hi < 2000) begin
      if (hi == 5) ACK_RECEIVED = 1'b1;
      @(posedge CLK); #1;
      hi++;
      if (hi == 6) begin
        ACK_RECEIVED = 1'b0;
        n_checks++;
        if (CL_DONE !== '0) begin
          $display("FAIL ack_outside_stream: CL_DONE=%b, required 000", CL_DONE); n_fail++;
        end
      end
    end
    n_checks++;
    if (hi != TMO) begin
      $display("FAIL timeout_len: REQ_TX high %0d cycles, required %0d", hi, TMO); n_fail++;
    end
    n_checks++;
    if (CL_FAIL !== 3'b001 || CL_DONE !== 3'b000) begin
      $display("FAIL timeout_result: fail=%b done=%b, required 001 000", CL_FAIL, CL_DONE); n_fail++;
    end
    CL_REQ[0] = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    wait_req(ok);
    n_checks++;
    if (!ok || GRANT_ID !== 2'd2) begin
      $display("FAIL midrst_grant: req_tx=%b grant=%0d, required 1 and 2", REQ_TX, GRANT_ID); n_fail++;
    end
    ACK_TX = 1'b1;
    @(posedge CLK); #1;
    ACK_TX = 1'b0;
    WORD_INDICATOR = ~WORD_INDICATOR;
    @(posedge CLK); #1;
    #2;
    RESET = 1'b0;
    #1;
    n_checks++;
    if ({BUSY, REQ_TX, PENDING, GRANT_ID, ADDR_IN} !== '0) begin
      $display("FAIL midrst_ctrl: busy=%b req=%b pend=%b grant=%0d addr=%h, required 0",
               BUSY, REQ_TX, PENDING, GRANT_ID, ADDR_IN); n_fail++;
    end
    n_checks++;
    if ({DATA_IN0, DATA_IN1} !== '0) begin
      $display("FAIL midrst_data: d0=%h d1=%h, required 0", DATA_IN0, DATA_IN1); n_fail++;
    end
    CL_REQ = '0;
    WORD_INDICATOR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({CL_WACK, CL_DONE, CL_FAIL} !== '0) begin
      $display("FAIL midrst_no_report: wack=%b done=%b fail=%b, required 0", CL_WACK, CL_DONE, CL_FAIL); n_fail++;
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    arm(0, 8'h31, 2, 32'h31310001, 32'h31310002, '0, '0);
    arm(2, 8'h32, 1, 32'h32320001, '0, '0, '0);
    CL_REQ = 3'b101;
    serve(0, 2, 8'h31, 1'b0);
    serve(2, 1, 8'h32, 1'b0);
  endtask

  initial begin : p_main
    RESET = 1'b0;
    CL_REQ = '0;
    ACK_TX = 1'b0;
    WORD_INDICATOR = 1'b0;
    ACK_RECEIVED = 1'b0;
    TX_FAIL = 1'b0;
    for (int c = 0; c < N; c++) begin
      wcnt[c] = 0; widx[c] = 0; wack_cnt[c] = 0; caddr[c] = '0;
      for (int k = 0; k < 4; k++) words[c][k] = '0;
    end
    test_reset();
    test_single_word();
    test_four_word();
    test_arbitration();
    test_failure();
    test_timeout();
    test_reset_mid_stream();
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL sb_leftover: %0d expected words never acked, required 0", exp_q.size()); n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
